// File: rtl/spi_cmd_controller.sv
// spi_cmd_controller: turns the spi_slave byte stream into register commands.
// A frame is CMD, ADDR, then words of DATA_BYTES bytes (MSB byte first).
// Writes and reads burst with address auto-increment. Read data goes back out on send.
module spi_cmd_controller #(
  parameter int ADDR_W     = 8,
  parameter int DATA_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    csn,
  input  logic [7:0]              recv,
  input  logic                    recv_valid,
  output logic [7:0]              send,
  output logic [ADDR_W-1:0]       reg_addr,
  output logic                    reg_wr_en,
  output logic [8*DATA_BYTES-1:0] reg_wr_data,
  output logic                    reg_rd_en,
  input  logic [8*DATA_BYTES-1:0] reg_rd_data,
  output logic                    frame_err,
  output logic [7:0]              err_count
);

  localparam int DATA_W = 8 * DATA_BYTES;
  localparam int CNT_W  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  // S_RCAP is the second cycle of the read fetch, where the registered read data arrives.
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_RFETCH, S_RCAP, S_RDATA, S_DISCARD
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_op_write;
  logic [DATA_W-1:0]   r_word;
  logic [DATA_W-1:0]   r_shift;
  logic [7:0]          r_send;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr_en;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_err;
  logic [7:0]          r_err_count;

  logic                w_byte;
  logic                w_last;
  logic                w_legal_op;
  logic                w_abort;
  logic                w_illegal;
  logic [DATA_W-1:0]   w_word_shift;
  logic [ADDR_W-1:0]   w_addr_byte;

  // The ADDR byte is zero-extended or truncated to the register address width.
  generate
    if (ADDR_W > 8) begin : g_addr_ext
      assign w_addr_byte = {{(ADDR_W-8){1'b0}}, recv};
    end else if (ADDR_W == 8) begin : g_addr_eq
      assign w_addr_byte = recv;
    end else begin : g_addr_trunc
      assign w_addr_byte = recv[ADDR_W-1:0];
    end
  endgenerate

  // A byte only counts while the chip is selected.
  assign w_byte       = recv_valid && !csn;
  assign w_last       = (r_cnt == CNT_W'(DATA_BYTES - 1));
  assign w_legal_op   = (recv == OP_WRITE) || (recv == OP_READ);
  assign w_word_shift = (r_word << 8) | DATA_W'(recv);
  assign w_illegal    = (r_state == S_IDLE) && w_byte && !w_legal_op;

  // Deselect outside IDLE, DISCARD or a word boundary ends a frame mid-command.
  assign w_abort = csn && ((r_state == S_ADDR) || (r_state == S_RFETCH) ||
                           (r_state == S_RCAP) ||
                           (((r_state == S_WDATA) || (r_state == S_RDATA)) && (r_cnt != '0)));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; deselect always returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    if (csn) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_byte) w_state_next = w_legal_op ? S_ADDR : S_DISCARD;
        S_ADDR:    if (w_byte) w_state_next = r_op_write ? S_WDATA : S_RFETCH;
        S_WDATA:   w_state_next = S_WDATA;
        S_RFETCH:  w_state_next = S_RCAP;
        S_RCAP:    w_state_next = S_RDATA;
        S_RDATA:   if (w_byte && w_last) w_state_next = S_RFETCH;
        S_DISCARD: w_state_next = S_DISCARD;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  // Datapath: opcode/address capture, word assembly, read shift-out, strobes and errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_op_write  <= 1'b0;
      r_word      <= '0;
      r_shift     <= '0;
      r_send      <= 8'h00;
      r_addr      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_err       <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      r_wr_en <= 1'b0;
      r_err   <= w_abort || w_illegal;
      if ((w_abort || w_illegal) && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
      // Address advances the cycle after each write strobe.
      if (r_wr_en) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      if (csn) begin
        r_cnt  <= '0;
        r_send <= 8'h00;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_byte) r_op_write <= (recv == OP_WRITE);
          end
          S_ADDR: begin
            if (w_byte) begin
              r_addr <= w_addr_byte;
              r_cnt  <= '0;
            end
          end
          S_WDATA: begin
            if (w_byte) begin
              r_word <= w_word_shift;
              if (w_last) begin
                r_cnt     <= '0;
                r_wr_en   <= 1'b1;
                r_wr_data <= w_word_shift;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          S_RCAP: begin
            r_send  <= reg_rd_data[DATA_W-1 -: 8];
            r_shift <= reg_rd_data << 8;
            r_cnt   <= '0;
          end
          S_RDATA: begin
            if (w_byte) begin
              if (w_last) begin
                r_cnt  <= '0;
                r_send <= 8'h00;
                r_addr <= r_addr + ADDR_W'(1);
              end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_send  <= r_shift[DATA_W-1 -: 8];
                r_shift <= r_shift << 8;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign send        = r_send;
  assign reg_addr    = r_addr;
  assign reg_wr_en   = r_wr_en;
  assign reg_wr_data = r_wr_data;
  assign reg_rd_en   = (r_state == S_RFETCH);
  assign frame_err   = r_err;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Bench for spi_cmd_controller: directed frames, scoreboard of expected register strobes.
module tb_spi_cmd_controller;

  logic        clk;
  logic        rst;
  logic        csn;
  logic [7:0]  recv;
  logic        recv_valid;
  logic [7:0]  send;
  logic [7:0]  reg_addr;
  logic        reg_wr_en;
  logic [15:0] reg_wr_data;
  logic        reg_rd_en;
  logic [15:0] reg_rd_data;
  logic        frame_err;
  logic [7:0]  err_count;

  spi_cmd_controller #(.ADDR_W(8), .DATA_BYTES(2)) dut (
    .clk(clk), .rst(rst), .csn(csn), .recv(recv), .recv_valid(recv_valid),
    .send(send), .reg_addr(reg_addr), .reg_wr_en(reg_wr_en),
    .reg_wr_data(reg_wr_data), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .frame_err(frame_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [7:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          err_pulses = 0;
  int          rd_pulses = 0;
  logic [15:0] regs [256];

  // Register file model with one-cycle registered read.
  always @(posedge clk) begin
    if (reg_rd_en) reg_rd_data <= regs[reg_addr];
  end

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (frame_err) err_pulses++;
      if (reg_rd_en) rd_pulses++;
      if (reg_wr_en && reg_rd_en) begin
        checks++; errors++;
        $display("FAIL strobe_overlap wr_en=1 rd_en=1 required never both");
      end
      if (reg_wr_en || reg_rd_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe wr=%0b addr=%h data=%h required none",
                   reg_wr_en, reg_addr, reg_wr_data);
        end else begin
          e = exp_q.pop_front();
          if (reg_wr_en !== e.is_wr || reg_addr !== e.addr ||
              (e.is_wr && reg_wr_data !== e.data)) begin
            errors++;
            $display("FAIL strobe wr=%0b addr=%h data=%h required wr=%0b addr=%h data=%h",
                     reg_wr_en, reg_addr, reg_wr_data, e.is_wr, e.addr, e.data);
          end else begin
            $display("strobe wr=%0b addr=%h data=%h ok", reg_wr_en, reg_addr,
                     e.is_wr ? reg_wr_data : reg_rd_data);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
    exp_t e;
    e.is_wr = 1'b1; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [7:0] a);
    exp_t e;
    e.is_wr = 1'b0; e.addr = a; e.data = 16'h0000;
    exp_q.push_back(e);
  endtask

  // One byte transfer; sent is the byte spi_slave was shifting out during it.
  task automatic put_byte(input logic [7:0] b, input int gap, output logic [7:0] sent);
    @(negedge clk);
    sent = send;
    recv = b;
    recv_valid = 1'b1;
    @(negedge clk);
    recv_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    csn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    csn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] rd_bytes [4];
    logic [7:0] exp_rd [4];
    int e0;
    int r0;

    exp_rd[0] = 8'hBE; exp_rd[1] = 8'hEF; exp_rd[2] = 8'hCA; exp_rd[3] = 8'hFE;
    for (int i = 0; i < 256; i++) regs[i] = 16'h0000;
    regs[8'h20] = 16'hBEEF;
    regs[8'h21] = 16'hCAFE;
    reg_rd_data = 16'h0000;
    rst = 1'b1; csn = 1'b1; recv = 8'h00; recv_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_send", send, 8'h00);
    chk("rst_addr", reg_addr, 8'h00);
    chk("rst_wr_en", reg_wr_en, 0);
    chk("rst_rd_en", reg_rd_en, 0);
    chk("rst_wr_data", reg_wr_data, 16'h0000);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_count", err_count, 8'h00);

    // Single write
    e0 = err_pulses;
    push_wr(8'h10, 16'h1234);
    cs_low();
    put_byte(8'h01, 4, s); put_byte(8'h10, 4, s); put_byte(8'h12, 4, s); put_byte(8'h34, 4, s);
    cs_high();
    chk("wr_no_err", err_pulses - e0, 0);
    chk("wr_addr_incr", reg_addr, 8'h11);

    // Burst write with address wrap
    e0 = err_pulses;
    push_wr(8'hFF, 16'hAABB);
    push_wr(8'h00, 16'hCCDD);
    cs_low();
    put_byte(8'h01, 4, s); put_byte(8'hFF, 4, s);
    put_byte(8'hAA, 4, s); put_byte(8'hBB, 4, s); put_byte(8'hCC, 4, s); put_byte(8'hDD, 4, s);
    cs_high();
    chk("burst_no_err", err_pulses - e0, 0);
    chk("burst_addr_end", reg_addr, 8'h01);

    // Burst read; the strobe at 0x22 is the prefetch after the second word completes
    e0 = err_pulses;
    r0 = rd_pulses;
    push_rd(8'h20); push_rd(8'h21); push_rd(8'h22);
    cs_low();
    put_byte(8'h02, 4, s);
    chk("rd_send_cmd", s, 8'h00);
    put_byte(8'h20, 4, s);
    chk("rd_send_addr", s, 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("rd_pulses_in_4_bytes", rd_pulses - r0, 2);
      put_byte(8'h00, 4, rd_bytes[i]);
      chk($sformatf("rd_send_%0d", i), rd_bytes[i], exp_rd[i]);
    end
    cs_high();
    chk("rd_no_err", err_pulses - e0, 0);
    chk("rd_send_idle", send, 8'h00);

    // Illegal opcode, then a legal frame
    e0 = err_pulses;
    cs_low();
    put_byte(8'h7F, 4, s); put_byte(8'h10, 4, s); put_byte(8'h12, 4, s); put_byte(8'h34, 4, s);
    cs_high();
    chk("illegal_err_pulses", err_pulses - e0, 1);
    chk("illegal_err_count", err_count, 8'h01);
    push_wr(8'h30, 16'h5678);
    cs_low();
    put_byte(8'h01, 4, s); put_byte(8'h30, 4, s); put_byte(8'h56, 4, s); put_byte(8'h78, 4, s);
    cs_high();
    chk("after_illegal_no_err", err_pulses - e0, 1);

    // Partial word abort
    e0 = err_pulses;
    cs_low();
    put_byte(8'h01, 4, s); put_byte(8'h10, 4, s); put_byte(8'h12, 4, s);
    cs_high();
    chk("abort_err_pulses", err_pulses - e0, 1);
    chk("abort_err_count", err_count, 8'h02);

    // Saturation: many aborts in ADDR
    e0 = err_pulses;
    for (int i = 0; i < 260; i++) begin
      cs_low();
      put_byte(8'h01, 1, s);
      cs_high();
    end
    chk("sat_err_pulses", err_pulses - e0, 260);
    chk("sat_err_count", err_count, 8'hFF);

    // Reset one cycle after the third byte of a write
    cs_low();
    put_byte(8'h01, 4, s); put_byte(8'h10, 4, s); put_byte(8'h12, 0, s);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_send", send, 8'h00);
    chk("midrst_addr", reg_addr, 8'h00);
    chk("midrst_wr_en", reg_wr_en, 0);
    chk("midrst_rd_en", reg_rd_en, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_err_count", err_count, 8'h00);
    cs_high();
    e0 = err_pulses;
    push_wr(8'h40, 16'h9ABC);
    cs_low();
    put_byte(8'h01, 4, s); put_byte(8'h40, 4, s); put_byte(8'h9A, 4, s); put_byte(8'hBC, 4, s);
    cs_high();
    chk("midrst_next_no_err", err_pulses - e0, 0);
    chk("midrst_err_count_after", err_count, 8'h00);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
